interrupt_injector: RTL and testbench
=====================================

// Module: interrupt_injector
// PURPOSE
//  Upstream of CPU; turns the raw jump button and 60 Hz frame tick into interrupt instructions.
//  Synchronises and debounces jump; queues one pending event per source.
//  Presents a registered jal-style instruction (opcode 5'b00011) to CPU.interrupt_instruction.
//  Holds it under a valid/ack handshake; drives 32'd0 (nop) otherwise.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000    clk cycles jump must be stable before accepted (>=2)
//  JUMP_VEC         27'd100   handler target for jump event
//  FRAME_VEC        27'd200   handler target for frame event
//  ACK_TIMEOUT      64        cycles in ISSUE without ack before event is dropped (>=1)
// PORTS
//  clk                    in   1   processor clock; all state on rising edge
//  reset                  in   1   asynchronous, active-low; 0 clears all state
//  jump                   in   1   raw async button, active-high
//  frame_tick             in   1   one-clk pulse per game frame, synchronous to clk
//  irq_ack                in   1   CPU accepted instruction this cycle (sampled only in ISSUE)
//  interrupt_instruction  out  32  {5'b00011, vec} while irq_valid, else 32'd0
//  irq_valid              out  1   instruction valid, held until ack or timeout
//  irq_src                out  1   0 = jump, 1 = frame; meaningful when irq_valid
//  timeout_err            out  1   one-clk pulse when an issued event times out
//  frame_drops            out  16  saturating count of frame ticks lost (FRAME_DROP_CNT_EN only)
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, pendings 0, FSM IDLE, debounce state 0.
//  Sync: jump -> 2 FFs -> jump_s. Debounce: if jump_s != stable, cnt++; else cnt=0.
//   When cnt reaches DEBOUNCE_CYCLES-1, stable<=jump_s and cnt<=0.
//   Rising edge of stable sets jump_pend. Falling edge does nothing.
//  frame_tick=1 sets frame_pend.
//  Set wins over clear: an event arriving in the same cycle its pending is consumed stays pending.
//  FSM IDLE:
//   - jump_pend set -> ISSUE; load JUMP_VEC, irq_src=0, clear jump_pend. Jump has priority.
//   - else frame_pend set -> ISSUE; load FRAME_VEC, irq_src=1, clear frame_pend.
//  FSM ISSUE: irq_valid=1; instruction and irq_src stable.
//   - irq_ack=1 -> IDLE; irq_valid=0 and instruction=0 next cycle.
//   - ACK_TIMEOUT cycles without ack -> IDLE; timeout_err=1 one cycle; event discarded.
//   - Ack on the timeout cycle counts as ack: no error.
//  Latency: pending visible in IDLE at cycle N -> irq_valid=1 at N+1.
//   Min 2 cycles between successive issues (1 IDLE cycle).
//  Pending flags are 1-deep; a repeat event while pending is merged.
//  Ack outside ISSUE is ignored.
//  Reset asserted mid-ISSUE: outputs drop to 0 immediately; no ack or error is generated.
// CONFIGURATION
//  FRAME_DROP_CNT_EN defined: frame_tick while frame_pend=1 (not being consumed that cycle)
//   increments frame_drops, saturating at 16'hFFFF; cleared only by reset.
//  FRAME_DROP_CNT_EN undefined: no counter logic; frame_drops tied to 16'd0.
// TESTING
//  1 Reset low mid-ISSUE -> same cycle irq_valid=0, instruction=0; after release, IDLE, no spurious issue.
//  2 DEBOUNCE_CYCLES=4; jump glitch of 3 clks -> no issue.
//    jump held 10 clks -> one issue, instruction=32'h18000064, irq_src=0; ack -> nop next cycle.
//  3 frame_tick and debounced jump edge same cycle -> jump issued first;
//    after ack, IDLE 1 clk, then frame issued (32'h180000C8, irq_src=1).
//  4 Frame issued, irq_ack held 0 for ACK_TIMEOUT=64 cycles -> timeout_err pulse, irq_valid=0,
//    frame_pend unaffected by dropped event.
//  5 FRAME_DROP_CNT_EN: 3 frame_ticks while ISSUE stalls on jump (no ack)
//    -> frame_drops=2, one frame issued later.
//    Undefined -> frame_drops=0.
//  6 frame_tick in the same cycle IDLE consumes frame_pend -> frame_pend stays 1; second frame issued after ack.

Source files
------------

// File: rtl/interrupt_injector.sv
// Turns the raw jump button and the frame tick into jal-style interrupt instructions for the CPU.
// Optional feature: define FRAME_DROP_CNT_EN to count frame ticks lost while a frame is already pending.
module interrupt_injector #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [26:0] JUMP_VEC        = 27'd100,
    parameter logic [26:0] FRAME_VEC       = 27'd200,
    parameter int unsigned ACK_TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump,
    input  logic        frame_tick,
    input  logic        irq_ack,
    output logic [31:0] interrupt_instruction,
    output logic        irq_valid,
    output logic        irq_src,
    output logic        timeout_err,
    output logic [15:0] frame_drops
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [4:0]  OPCODE = 5'b00011;

    typedef enum logic {IDLE, ISSUE} state_e;

    logic             jump_meta_q, jump_s_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             jump_rise_c;
    logic             jump_pend_q, jump_pend_d;
    logic             frame_pend_q, frame_pend_d;
    logic             consume_jump_c, consume_frame_c;
    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_hit_c;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             src_q, src_d;
    logic             terr_q, terr_d;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jump_meta_q <= 1'b0;
            jump_s_q    <= 1'b0;
        end else begin
            jump_meta_q <= jump;
            jump_s_q    <= jump_meta_q;
        end
    end

    // Debounce: accept a new level only after it has differed from stable for DEBOUNCE_CYCLES
    always_comb begin
        cnt_d       = '0;
        stable_d    = stable_q;
        jump_rise_c = 1'b0;
        if (jump_s_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d    = jump_s_q;
                jump_rise_c = jump_s_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // One-deep pending flags; a new event beats a same-cycle consume
    always_comb begin
        jump_pend_d  = jump_rise_c | (jump_pend_q & ~consume_jump_c);
        frame_pend_d = frame_tick  | (frame_pend_q & ~consume_frame_c);
    end

    assign timeout_hit_c = (tmr_q == TMR_W'(ACK_TIMEOUT - 1));

    // FSM state register and all other sequential state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q     <= 1'b0;
            cnt_q        <= '0;
            jump_pend_q  <= 1'b0;
            frame_pend_q <= 1'b0;
            state_q      <= IDLE;
            tmr_q        <= '0;
            instr_q      <= 32'd0;
            valid_q      <= 1'b0;
            src_q        <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            jump_pend_q  <= jump_pend_d;
            frame_pend_q <= frame_pend_d;
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            src_q        <= src_d;
            terr_q       <= terr_d;
        end
    end

    // Next-state: jump beats frame; ack beats timeout
    always_comb begin
        state_d         = state_q;
        tmr_d           = tmr_q;
        consume_jump_c  = 1'b0;
        consume_frame_c = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (jump_pend_q) begin
                    state_d        = ISSUE;
                    consume_jump_c = 1'b1;
                end else if (frame_pend_q) begin
                    state_d         = ISSUE;
                    consume_frame_c = 1'b1;
                end
            end
            ISSUE: begin
                if (irq_ack || timeout_hit_c) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, computed one cycle ahead of the state they describe
    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        src_d   = src_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                instr_d = 32'd0;
                valid_d = 1'b0;
                if (jump_pend_q) begin
                    instr_d = {OPCODE, JUMP_VEC};
                    valid_d = 1'b1;
                    src_d   = 1'b0;
                end else if (frame_pend_q) begin
                    instr_d = {OPCODE, FRAME_VEC};
                    valid_d = 1'b1;
                    src_d   = 1'b1;
                end
            end
            ISSUE: begin
                if (irq_ack) begin
                    instr_d = 32'd0;
                    valid_d = 1'b0;
                end else if (timeout_hit_c) begin
                    instr_d = 32'd0;
                    valid_d = 1'b0;
                    terr_d  = 1'b1;
                end
            end
            default: begin
                instr_d = 32'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign interrupt_instruction = instr_q;
    assign irq_valid             = valid_q;
    assign irq_src               = src_q;
    assign timeout_err           = terr_q;

`ifdef FRAME_DROP_CNT_EN
    logic [15:0] drops_q;

    // Saturating count of ticks merged into an already-pending frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drops_q <= 16'd0;
        end else if (frame_tick && frame_pend_q && !consume_frame_c && (drops_q != 16'hFFFF)) begin
            drops_q <= drops_q + 16'd1;
        end
    end

    assign frame_drops = drops_q;
`else
    assign frame_drops = 16'd0;
`endif

endmodule

// File: tb/tb_interrupt_injector.sv
// Scoreboard bench for interrupt_injector (DEBOUNCE_CYCLES=4, ACK_TIMEOUT=64); honours FRAME_DROP_CNT_EN.
module tb_interrupt_injector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        jump = 1'b0;
    logic        frame_tick = 1'b0;
    logic        irq_ack = 1'b0;
    logic [31:0] interrupt_instruction;
    logic        irq_valid;
    logic        irq_src;
    logic        timeout_err;
    logic [15:0] frame_drops;

    typedef struct {
        logic [31:0] instr;
        logic        src;
    } exp_t;

    localparam logic [31:0] JUMP_INSTR  = 32'h18000064;
    localparam logic [31:0] FRAME_INSTR = 32'h180000C8;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;
    int   exp_drops = 0;

    interrupt_injector #(
        .DEBOUNCE_CYCLES(4),
        .JUMP_VEC       (27'd100),
        .FRAME_VEC      (27'd200),
        .ACK_TIMEOUT    (64)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .jump                 (jump),
        .frame_tick           (frame_tick),
        .irq_ack              (irq_ack),
        .interrupt_instruction(interrupt_instruction),
        .irq_valid            (irq_valid),
        .irq_src              (irq_src),
        .timeout_err          (timeout_err),
        .frame_drops          (frame_drops)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: each new issue pops the scoreboard; nop whenever not valid
    always @(negedge clk) begin
        if (reset && irq_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_issue", 32'(irq_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_instr", interrupt_instruction, e.instr);
                check("issue_src", 32'(irq_src), 32'(e.src));
            end
        end
        if (!irq_valid) check("nop_when_idle", interrupt_instruction, 32'd0);
        prev_valid = irq_valid;
    end

    task automatic push_exp(input logic [31:0] instr, input logic src);
        exp_t e;
        e.instr = instr;
        e.src   = src;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (!irq_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(irq_valid), 32'd1);
    endtask

    task automatic do_ack(input string tag);
        @(posedge clk);
        #1 irq_ack = 1'b1;
        @(posedge clk);
        #1 irq_ack = 1'b0;
        @(negedge clk);
        check(tag, 32'(irq_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        idle_cycles(3);
        @(negedge clk);
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_instr", interrupt_instruction, 32'd0);
        check("rst_src", 32'(irq_src), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_drops", 32'(frame_drops), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Ack outside ISSUE has no effect
        idle_cycles(2);
        irq_ack = 1'b1;
        idle_cycles(1);
        irq_ack = 1'b0;
        idle_cycles(5);
        @(negedge clk);
        check("stray_ack", 32'(irq_valid), 32'd0);

        // 3-clock glitch is filtered out
        @(posedge clk);
        #1 jump = 1'b1;
        idle_cycles(3);
        jump = 1'b0;
        idle_cycles(20);
        @(negedge clk);
        check("glitch_no_issue", 32'(irq_valid), 32'd0);

        // Held jump -> one issue, ack -> nop
        push_exp(JUMP_INSTR, 1'b0);
        @(posedge clk);
        #1 jump = 1'b1;
        idle_cycles(10);
        jump = 1'b0;
        wait_valid("jump_wait", 30);
        do_ack("jump_ack_valid");
        idle_cycles(12);

        // Frame and debounced jump edge together: jump, one idle cycle, then frame
        push_exp(JUMP_INSTR, 1'b0);
        push_exp(FRAME_INSTR, 1'b1);
        @(posedge clk);
        #1 jump = 1'b1;
        repeat (5) @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        jump = 1'b0;
        wait_valid("coinc_jump_wait", 10);
        check("coinc_first_src", 32'(irq_src), 32'd0);
        do_ack("coinc_gap");
        @(negedge clk);
        check("coinc_frame_valid", 32'(irq_valid), 32'd1);
        check("coinc_frame_src", 32'(irq_src), 32'd1);
        do_ack("coinc_frame_ack");
        idle_cycles(12);

        // Timeout after 64 unacked cycles; dropped event is not re-queued
        begin
            int n = 1;
            push_exp(FRAME_INSTR, 1'b1);
            pulse_frame();
            wait_valid("to_wait", 10);
            while (n < 200) begin
                @(negedge clk);
                if (!irq_valid) break;
                n++;
            end
            check("to_valid_cycles", 32'(n), 32'd64);
            check("to_err_pulse", 32'(timeout_err), 32'd1);
            check("to_valid_low", 32'(irq_valid), 32'd0);
            @(negedge clk);
            check("to_err_one_cycle", 32'(timeout_err), 32'd0);
            idle_cycles(10);
            @(negedge clk);
            check("to_no_reissue", 32'(irq_valid), 32'd0);
        end

        // Same-cycle tick while IDLE consumes frame_pend keeps it pending
        push_exp(FRAME_INSTR, 1'b1);
        push_exp(FRAME_INSTR, 1'b1);
        @(posedge clk);
        #1 frame_tick = 1'b1;
        idle_cycles(2);
        frame_tick = 1'b0;
        wait_valid("refill_wait1", 10);
        do_ack("refill_ack1");
        wait_valid("refill_wait2", 5);
        do_ack("refill_ack2");
        idle_cycles(5);
        check("refill_drops", 32'(frame_drops), 32'd0);

        // Frame ticks while jump stalls in ISSUE
        push_exp(JUMP_INSTR, 1'b0);
        push_exp(FRAME_INSTR, 1'b1);
        @(posedge clk);
        #1 jump = 1'b1;
        wait_valid("stall_jump_wait", 30);
        repeat (3) begin
            pulse_frame();
            idle_cycles(2);
        end
`ifdef FRAME_DROP_CNT_EN
        exp_drops = 2;
`else
        exp_drops = 0;
`endif
        @(negedge clk);
        check("stall_src_jump", 32'(irq_src), 32'd0);
        check("stall_drops", 32'(frame_drops), 32'(exp_drops));
        do_ack("stall_jump_ack");
        wait_valid("stall_frame_wait", 5);
        do_ack("stall_frame_ack");
        jump = 1'b0;
        idle_cycles(15);
        @(negedge clk);
        check("stall_single_frame", 32'(irq_valid), 32'd0);

        // Reset mid-ISSUE drops outputs immediately
        push_exp(FRAME_INSTR, 1'b1);
        pulse_frame();
        wait_valid("rst_mid_wait", 10);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(irq_valid), 32'd0);
        check("rst_mid_instr", interrupt_instruction, 32'd0);
        check("rst_mid_terr", 32'(timeout_err), 32'd0);
        check("rst_mid_drops", 32'(frame_drops), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle_cycles(70);
        @(negedge clk);
        check("rst_mid_no_issue", 32'(irq_valid), 32'd0);
        check("rst_mid_no_terr", 32'(timeout_err), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
